parking_gate_ctrl: RTL and testbench

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

---
 rtl/parking_gate_ctrl.sv | 162 ++++++++++++++++
 tb/tb_parking_gate_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: PIN-guarded entry gate with attempt limit,
// idle timeout, tailgating block and saturating occupancy counter.
// Moore FSM; every output is a flop loaded from next-state values.
module parking_gate_ctrl #(
  parameter int                PIN_W        = 8,
  parameter logic [PIN_W-1:0]  PIN_OK       = PIN_W'(8'h08),
  parameter int                MAX_INTENTOS = 3,
  parameter int                TIMEOUT      = 16,
  parameter int                CAPACIDAD    = 8,
  localparam int               CNT_W        = $clog2(CAPACIDAD + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Vehiculo,
  input  logic             Termino,
  input  logic             Salida,
  input  logic             enterPin,
  input  logic [PIN_W-1:0] Pin,
  output logic             Cerrado,
  output logic             Abierto,
  output logic             Alarma,
  output logic             Bloqueo,
  output logic             Lleno,
  output logic [CNT_W-1:0] Ocupacion
);

  typedef enum logic [2:0] {
    ESPERA  = 3'd0,
    PIN     = 3'd1,
    ABIERTO = 3'd2,
    ALARMA  = 3'd3,
    BLOQUEO = 3'd4
  } state_t;

  localparam logic [3:0]       MAX_T = 4'(MAX_INTENTOS);
  localparam logic [15:0]      TOUT  = 16'(TIMEOUT);
  localparam logic [CNT_W-1:0] CAP   = CNT_W'(CAPACIDAD);

  state_t           state_reg, state_next;
  logic [3:0]       tries_reg, tries_next;
  logic [15:0]      idle_reg, idle_next;
  logic [CNT_W-1:0] occ_reg, occ_next;
  logic             en_prev_reg;
  logic             cerrado_reg, abierto_reg, alarma_reg, bloqueo_reg, lleno_reg;
  logic             attempt;
  logic             pin_ok;
  logic             inc;

  // An attempt is only the rising edge of enterPin; the edge register is
  // cleared by reset, and reset always lands in ESPERA where attempts are
  // ignored, so a level held across reset release never counts.
  assign attempt = enterPin & ~en_prev_reg;
  assign pin_ok  = (Pin == PIN_OK);

  // Next-state, attempt/idle counter and entry-increment decisions.
  always_comb begin
    state_next = state_reg;
    tries_next = tries_reg;
    idle_next  = '0;
    inc        = 1'b0;
    case (state_reg)
      ESPERA: begin
        if (Vehiculo && !lleno_reg) begin
          state_next = PIN;
        end
      end
      PIN: begin
        if (attempt) begin
          // Any attempt restarts the idle counter (idle_next stays 0).
          if (pin_ok) begin
            state_next = ABIERTO;
            tries_next = '0;
          end else if (tries_reg + 4'd1 == MAX_T) begin
            state_next = ALARMA;
            tries_next = MAX_T;
          end else begin
            tries_next = tries_reg + 4'd1;
          end
        end else if (!Vehiculo) begin
          state_next = ESPERA;
          tries_next = '0;
        end else if (idle_reg + 16'd1 == TOUT) begin
          state_next = ESPERA;
          tries_next = '0;
        end else begin
          idle_next = idle_reg + 16'd1;
        end
      end
      ALARMA: begin
        // Wrong attempts leave the counter parked at the limit.
        if (attempt && pin_ok) begin
          state_next = ESPERA;
          tries_next = '0;
        end
      end
      ABIERTO: begin
        if (Termino) begin
          inc        = 1'b1;
          state_next = Vehiculo ? BLOQUEO : ESPERA;
        end
      end
      BLOQUEO: begin
        if (attempt && pin_ok) begin
          state_next = ESPERA;
        end
      end
      default: begin
        state_next = ESPERA;
        tries_next = '0;
      end
    endcase
  end

  // Occupancy: entry and exit in the same cycle cancel; both ends saturate.
  always_comb begin
    occ_next = occ_reg;
    if (inc && !Salida) begin
      if (occ_reg != CAP) begin
        occ_next = occ_reg + 1'b1;
      end
    end else if (!inc && Salida) begin
      if (occ_reg != '0) begin
        occ_next = occ_reg - 1'b1;
      end
    end
  end

  // State, counters and registered Moore outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg   <= ESPERA;
      tries_reg   <= '0;
      idle_reg    <= '0;
      occ_reg     <= '0;
      en_prev_reg <= 1'b0;
      cerrado_reg <= 1'b1;
      abierto_reg <= 1'b0;
      alarma_reg  <= 1'b0;
      bloqueo_reg <= 1'b0;
      lleno_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tries_reg   <= tries_next;
      idle_reg    <= idle_next;
      occ_reg     <= occ_next;
      en_prev_reg <= enterPin;
      cerrado_reg <= (state_next != ABIERTO);
      abierto_reg <= (state_next == ABIERTO);
      alarma_reg  <= (state_next == ALARMA);
      bloqueo_reg <= (state_next == BLOQUEO);
      lleno_reg   <= (occ_next == CAP);
    end
  end

  assign Cerrado   = cerrado_reg;
  assign Abierto   = abierto_reg;
  assign Alarma    = alarma_reg;
  assign Bloqueo   = bloqueo_reg;
  assign Lleno     = lleno_reg;
  assign Ocupacion = occ_reg;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed scenarios with
// constant expectations, then randomized traffic against a reference model.
module tb_parking_gate_ctrl;

  localparam int         CAP   = 2;
  localparam int         TOUT  = 16;
  localparam int         MAXI  = 3;
  localparam logic [7:0] OKPIN = 8'h08;

  localparam int M_ESPERA  = 0;
  localparam int M_PIN     = 1;
  localparam int M_ABIERTO = 2;
  localparam int M_ALARMA  = 3;
  localparam int M_BLOQUEO = 4;

  logic       Clk, Reset, Vehiculo, Termino, Salida, enterPin;
  logic [7:0] Pin;
  logic       Cerrado, Abierto, Alarma, Bloqueo, Lleno;
  logic [1:0] Ocupacion;

  int vec  = 0;
  int miss = 0;

  // Reference model state
  int m_state, m_tries, m_idle, m_occ;
  bit m_prev;

  parking_gate_ctrl #(
    .PIN_W(8), .PIN_OK(8'h08), .MAX_INTENTOS(MAXI), .TIMEOUT(TOUT), .CAPACIDAD(CAP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Vehiculo(Vehiculo), .Termino(Termino),
    .Salida(Salida), .enterPin(enterPin), .Pin(Pin),
    .Cerrado(Cerrado), .Abierto(Abierto), .Alarma(Alarma), .Bloqueo(Bloqueo),
    .Lleno(Lleno), .Ocupacion(Ocupacion)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Bundle layout: {Cerrado, Abierto, Alarma, Bloqueo, Lleno, Ocupacion[1:0]}
  function automatic logic [6:0] outs();
    return {Cerrado, Abierto, Alarma, Bloqueo, Lleno, Ocupacion};
  endfunction

  function automatic logic [6:0] pk(int c, int a, int al, int b, int l, int o);
    return {c[0], a[0], al[0], b[0], l[0], o[1:0]};
  endfunction

  function automatic void model_reset();
    m_state = M_ESPERA;
    m_tries = 0;
    m_idle  = 0;
    m_occ   = 0;
    m_prev  = 1'b0;
  endfunction

  // One clock of the gate rules, evaluated on the inputs presented this cycle.
  function automatic void model_step();
    bit att;
    bit ok;
    int inc;
    int n;
    att = enterPin && !m_prev;
    ok  = (Pin == OKPIN);
    inc = 0;
    case (m_state)
      M_ESPERA: if (Vehiculo && m_occ < CAP) begin
        m_state = M_PIN;
        m_idle  = 0;
      end
      M_PIN: begin
        if (att) begin
          m_idle = 0;
          if (ok) begin
            m_state = M_ABIERTO;
            m_tries = 0;
          end else begin
            m_tries = m_tries + 1;
            if (m_tries >= MAXI) m_state = M_ALARMA;
          end
        end else if (!Vehiculo || m_idle + 1 >= TOUT) begin
          m_state = M_ESPERA;
          m_tries = 0;
          m_idle  = 0;
        end else begin
          m_idle = m_idle + 1;
        end
      end
      M_ALARMA: if (att && ok) begin
        m_state = M_ESPERA;
        m_tries = 0;
      end
      M_ABIERTO: if (Termino) begin
        inc     = 1;
        m_state = Vehiculo ? M_BLOQUEO : M_ESPERA;
      end
      M_BLOQUEO: if (att && ok) m_state = M_ESPERA;
      default: m_state = M_ESPERA;
    endcase
    n = m_occ + inc - int'(Salida);
    if (n < 0) n = 0;
    if (n > CAP) n = CAP;
    m_occ  = n;
    m_prev = enterPin;
  endfunction

  function automatic logic [6:0] model_outs();
    return pk(int'(m_state != M_ABIERTO), int'(m_state == M_ABIERTO),
              int'(m_state == M_ALARMA), int'(m_state == M_BLOQUEO),
              int'(m_occ == CAP), m_occ);
  endfunction

  task automatic tick();
    if (Reset) model_step();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset(input logic en_level);
    Reset    = 1'b0;
    Vehiculo = 1'b0;
    Termino  = 1'b0;
    Salida   = 1'b0;
    enterPin = en_level;
    Pin      = 8'h00;
    model_reset();
    @(posedge Clk);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
  endtask

  task automatic admit();
    Vehiculo = 1'b1; tick();
    enterPin = 1'b1; Pin = OKPIN; tick();
    enterPin = 1'b0; Vehiculo = 1'b0; Termino = 1'b1; tick();
    Termino = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset(1'b0);
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 0)) begin
      miss++; $display("FAIL reset_state: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_open();
    apply_reset(1'b0);
    Vehiculo = 1'b1; tick();
    enterPin = 1'b1; Pin = OKPIN; tick();
    vec++;
    if (outs() !== pk(0, 1, 0, 0, 0, 0)) begin
      miss++; $display("FAIL open_gate: got %b want %b", outs(), pk(0, 1, 0, 0, 0, 0));
    end
    enterPin = 1'b0; Vehiculo = 1'b0; Termino = 1'b1; tick();
    Termino = 1'b0;
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 1)) begin
      miss++; $display("FAIL open_pass: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 1));
    end
  endtask

  task automatic test_alarm();
    apply_reset(1'b0);
    Vehiculo = 1'b1; tick();
    for (int k = 1; k <= 4; k++) begin
      enterPin = 1'b1; Pin = 8'hFF; tick();
      vec++;
      if (Alarma !== (k >= 3)) begin
        miss++; $display("FAIL alarm_wrong%0d: got Alarma=%b want %b", k, Alarma, (k >= 3));
      end
      enterPin = 1'b0; tick();
    end
    Vehiculo = 1'b0;
    enterPin = 1'b1; Pin = OKPIN; tick();
    enterPin = 1'b0;
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 0)) begin
      miss++; $display("FAIL alarm_clear: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_held_enter();
    apply_reset(1'b0);
    Vehiculo = 1'b1; tick();
    enterPin = 1'b1; Pin = 8'hFF;
    repeat (5) tick();
    enterPin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      Pin = 8'(k == 1 ? 8'h08 : 8'h55); tick();
    end
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 0)) begin
      miss++; $display("FAIL held_once: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 0));
    end
    // Second wrong attempt must not alarm; third must.
    enterPin = 1'b1; Pin = 8'hFF; tick(); enterPin = 1'b0; tick();
    vec++;
    if (Alarma !== 1'b0) begin
      miss++; $display("FAIL held_second: got Alarma=%b want 0", Alarma);
    end
    enterPin = 1'b1; tick(); enterPin = 1'b0;
    vec++;
    if (Alarma !== 1'b1) begin
      miss++; $display("FAIL held_third: got Alarma=%b want 1", Alarma);
    end
  endtask

  task automatic test_tailgate();
    apply_reset(1'b0);
    Vehiculo = 1'b1; tick();
    enterPin = 1'b1; Pin = OKPIN; tick();
    enterPin = 1'b0; Termino = 1'b1; tick();
    vec++;
    if (outs() !== pk(1, 0, 0, 1, 0, 1)) begin
      miss++; $display("FAIL tail_block: got %b want %b", outs(), pk(1, 0, 0, 1, 0, 1));
    end
    Termino = 1'b0; Vehiculo = 1'b0; tick();
    Termino = 1'b1; tick(); Termino = 1'b0;
    vec++;
    if (outs() !== pk(1, 0, 0, 1, 0, 1)) begin
      miss++; $display("FAIL tail_hold: got %b want %b", outs(), pk(1, 0, 0, 1, 0, 1));
    end
    enterPin = 1'b1; Pin = OKPIN; tick(); enterPin = 1'b0;
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 1)) begin
      miss++; $display("FAIL tail_clear: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 1));
    end
  endtask

  task automatic test_capacity();
    apply_reset(1'b0);
    admit();
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 1)) begin
      miss++; $display("FAIL cap_one: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 1));
    end
    admit();
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 1, 2)) begin
      miss++; $display("FAIL cap_full: got %b want %b", outs(), pk(1, 0, 0, 0, 1, 2));
    end
    Vehiculo = 1'b1; tick();
    enterPin = 1'b1; Pin = OKPIN; tick(); enterPin = 1'b0;
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 1, 2)) begin
      miss++; $display("FAIL cap_refuse: got %b want %b", outs(), pk(1, 0, 0, 0, 1, 2));
    end
    Vehiculo = 1'b0; Salida = 1'b1; tick(); Salida = 1'b0;
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 1)) begin
      miss++; $display("FAIL cap_exit: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 1));
    end
    Salida = 1'b1; tick(); tick(); Salida = 1'b0;
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 0)) begin
      miss++; $display("FAIL cap_floor: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_timeout();
    // Attempt in the last allowed idle cycle still opens.
    apply_reset(1'b0);
    Vehiculo = 1'b1; tick();
    repeat (TOUT - 1) tick();
    enterPin = 1'b1; Pin = OKPIN; tick(); enterPin = 1'b0;
    vec++;
    if (outs() !== pk(0, 1, 0, 0, 0, 0)) begin
      miss++; $display("FAIL tout_edge: got %b want %b", outs(), pk(0, 1, 0, 0, 0, 0));
    end
    // Asynchronous reset while open: immediate close, no count.
    Vehiculo = 1'b0; Termino = 1'b1;
    #2 Reset = 1'b0;
    #1;
    model_reset();
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 0)) begin
      miss++; $display("FAIL reset_async: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 0));
    end
    @(posedge Clk); #1;
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 0)) begin
      miss++; $display("FAIL reset_hold: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 0));
    end
    Reset = 1'b1; Termino = 1'b0;
    // Full idle window expires; the next attempt lands in ESPERA.
    apply_reset(1'b0);
    Vehiculo = 1'b1; tick();
    repeat (TOUT) tick();
    enterPin = 1'b1; Pin = OKPIN; tick(); enterPin = 1'b0;
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 0)) begin
      miss++; $display("FAIL tout_expire: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_enter_across_reset();
    apply_reset(1'b1);
    Pin = OKPIN; Vehiculo = 1'b1;
    tick(); tick();
    vec++;
    if (outs() !== pk(1, 0, 0, 0, 0, 0)) begin
      miss++; $display("FAIL held_reset: got %b want %b", outs(), pk(1, 0, 0, 0, 0, 0));
    end
    enterPin = 1'b0; tick();
    enterPin = 1'b1; tick(); enterPin = 1'b0;
    vec++;
    if (outs() !== pk(0, 1, 0, 0, 0, 0)) begin
      miss++; $display("FAIL rearm_open: got %b want %b", outs(), pk(0, 1, 0, 0, 0, 0));
    end
  endtask

  task automatic test_random();
    logic [6:0] exp_v;
    apply_reset(1'b0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) apply_reset(1'b0);
      Vehiculo = ($urandom_range(0, 9) < 7);
      Termino  = ($urandom_range(0, 9) < 3);
      Salida   = ($urandom_range(0, 19) < 3);
      enterPin = ($urandom_range(0, 9) < 4);
      Pin      = ($urandom_range(0, 1) == 0) ? OKPIN : 8'($urandom);
      tick();
      exp_v = model_outs();
      vec++;
      if (outs() !== exp_v) begin
        miss++; $display("FAIL random_cycle%0d: got %b want %b", i, outs(), exp_v);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Vehiculo = 1'b0; Termino = 1'b0; Salida = 1'b0;
    enterPin = 1'b0; Pin = 8'h00;
    model_reset();
    test_reset();
    test_open();
    test_alarm();
    test_held_enter();
    test_tailgate();
    test_capacity();
    test_timeout();
    test_enter_across_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
